// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction codes and shared constants
package jtag_pkg;
  typedef enum logic [4:0] {
    TEST_LOGIC_RESET = 5'h00,
    RUN_TEST_IDLE    = 5'h01,
    SELECT_DR_SCAN   = 5'h02,
    SELECT_IR_SCAN   = 5'h03,
    CAPTURE_DR       = 5'h04,
    CAPTURE_IR       = 5'h05,
    SHIFT_DR         = 5'h06,
    SHIFT_IR         = 5'h07,
    EXIT1_DR         = 5'h08,
    EXIT1_IR         = 5'h09,
    PAUSE_DR         = 5'h10,
    PAUSE_IR         = 5'h11,
    EXIT2_DR         = 5'h12,
    EXIT2_IR         = 5'h13,
    UPDATE_DR        = 5'h14,
    UPDATE_IR        = 5'h15
  } tap_state_e;
  localparam logic [3:0] INSTR_ABORT  = 4'b1000;
  localparam logic [3:0] INSTR_IDCODE = 4'b1110;
  localparam logic [3:0] INSTR_BYPASS = 4'b1111;
  localparam logic [3:0] INSTR_USER   = 4'b0010;
  localparam logic [3:0] IR_CAPTURE   = 4'b0001;
  localparam int DR_WIDTH = 32;
endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: capture/shift register with selectable active length, LSB-first serial out
module jtag_shift_reg #(
  parameter int W = 4,
  parameter int PW = W,
  parameter logic [W-1:0] RST_VAL = '0,
  localparam int MW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_capture,
  input  logic          i_shift,
  input  logic [W-1:0]  i_cap_val,
  input  logic [MW-1:0] i_msb,
  input  logic          i_tdi,
  output logic          o_so,
  output logic [PW-1:0] o_q
);
  logic [W-1:0] r_q, w_sh;
  // tdi enters at the top of the active length; bits above it are don't-care
  always_comb begin
    w_sh = {i_tdi, r_q[W-1:1]};
    w_sh[i_msb] = i_tdi;
  end
  // capture has priority over shift; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) r_q <= RST_VAL;
    else if (i_capture) r_q <= i_cap_val;
    else if (i_shift) r_q <= w_sh;
  end
  assign o_so = r_q[0];
  assign o_q = r_q[PW-1:0];
endmodule

// File: rtl/jtag_tap_registers.sv
// jtag_tap_registers: IR, IDCODE, BYPASS and USER data registers behind the TAP FSM
module jtag_tap_registers import jtag_pkg::*; #(
  parameter int IR_WIDTH = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
  parameter int USER_WIDTH = 8,
  parameter logic [USER_WIDTH-1:0] USER_RESET = '0
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic [4:0]            tap_state,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_oe,
  output logic [IR_WIDTH-1:0]   ir_value,
  output logic                  abort_pulse,
  output logic [USER_WIDTH-1:0] user_data,
  output logic                  user_update
);
  localparam int IR_MW = $clog2(IR_WIDTH);
  localparam int DR_MW = $clog2(DR_WIDTH);
  logic [IR_WIDTH-1:0] w_ir_shift, r_ir_value;
  logic [USER_WIDTH-1:0] w_dr_low, r_user_data;
  logic [DR_WIDTH-1:0] w_dr_cap;
  logic [DR_MW-1:0] w_dr_msb;
  logic w_ir_so, w_dr_so, w_is_idcode, w_is_user, w_shift_ir, w_shift_dr;
  logic r_abort_pulse, r_user_update;
  // decode the active instruction into DR length and capture value; unknown codes act as BYPASS
  always_comb begin
    w_is_idcode = r_ir_value == IR_WIDTH'(INSTR_IDCODE);
    w_is_user = r_ir_value == IR_WIDTH'(INSTR_USER);
    w_dr_msb = w_is_idcode ? DR_MW'(DR_WIDTH-1) : w_is_user ? DR_MW'(USER_WIDTH-1) : '0;
    w_dr_cap = w_is_idcode ? IDCODE_VALUE : w_is_user ? DR_WIDTH'(r_user_data) : '0;
    w_shift_ir = tap_state == SHIFT_IR;
    w_shift_dr = tap_state == SHIFT_DR;
  end
  jtag_shift_reg #(.W(IR_WIDTH), .PW(IR_WIDTH), .RST_VAL(IR_WIDTH'(IR_CAPTURE))) u_ir (
    .clk(tck), .rst(trst), .i_capture(tap_state == CAPTURE_IR), .i_shift(w_shift_ir),
    .i_cap_val(IR_WIDTH'(IR_CAPTURE)), .i_msb(IR_MW'(IR_WIDTH-1)), .i_tdi(tdi),
    .o_so(w_ir_so), .o_q(w_ir_shift)
  );
  jtag_shift_reg #(.W(DR_WIDTH), .PW(USER_WIDTH), .RST_VAL('0)) u_dr (
    .clk(tck), .rst(trst), .i_capture(tap_state == CAPTURE_DR), .i_shift(w_shift_dr),
    .i_cap_val(w_dr_cap), .i_msb(w_dr_msb), .i_tdi(tdi),
    .o_so(w_dr_so), .o_q(w_dr_low)
  );
  // active instruction, USER data and the one-cycle strobes that follow their updates
  always_ff @(posedge tck) begin
    if (trst) begin
      r_ir_value <= IR_WIDTH'(INSTR_IDCODE);
      r_user_data <= USER_RESET;
      r_abort_pulse <= 1'b0;
      r_user_update <= 1'b0;
    end else begin
      r_abort_pulse <= tap_state == UPDATE_IR && w_ir_shift == IR_WIDTH'(INSTR_ABORT);
      r_user_update <= tap_state == UPDATE_DR && w_is_user;
      if (tap_state == TEST_LOGIC_RESET) r_ir_value <= IR_WIDTH'(INSTR_IDCODE);
      else if (tap_state == UPDATE_IR) r_ir_value <= w_ir_shift;
      if (tap_state == UPDATE_DR && w_is_user) r_user_data <= w_dr_low;
    end
  end
  assign tdo = !trst && (w_shift_ir ? w_ir_so : w_shift_dr && w_dr_so);
  assign tdo_oe = !trst && (w_shift_ir || w_shift_dr);
  assign ir_value = r_ir_value;
  assign user_data = r_user_data;
  assign abort_pulse = r_abort_pulse;
  assign user_update = r_user_update;
endmodule
